tick_to_level: RTL and testbench



---
 rtl/tick_to_level.sv | 150 +++++++++++++++
 tb/tb_tick_to_level.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tick_to_level.sv
// -----------------------------------------------------------------------------
// tick_to_level
//
// Purpose:
//    Stretches a single-cycle request tick into a level pulse whose length is
//    given by 'len' at the moment the tick is accepted. A Moore FSM walks
//    IDLE -> HIGH -> GAP -> IDLE. A down-counter times the HIGH phase, and a
//    second counter enforces a minimum low gap before the next pulse.
//    In retrigger mode a tick that arrives while the pulse is high reloads the
//    counter, so the pulse is extended rather than restarted.
//    Ticks that cannot be honoured are reported on dropped_tick.
//
// Parameters:
//    CNT_W    width of 'len' and of the pulse down-counter
//    MIN_LOW  forced low cycles after each pulse (0..255, 0 = no GAP state)
//
// Ports:
//    clk           rising-edge clock
//    reset         synchronous, active-high; overrides every other input
//    tick_in       request tick, sampled on the rising edge of clk
//    len           pulse length in cycles, sampled only when a tick is accepted
//    retrigger_en  1: a tick during HIGH reloads the counter, 0: it is dropped
//    level_out     stretched pulse (registered, high while in HIGH)
//    busy          high whenever the FSM is not IDLE (registered)
//    done_tick     one-cycle pulse after the edge on which the pulse falls
//    dropped_tick  one-cycle pulse after any edge on which a tick was ignored
// -----------------------------------------------------------------------------
module tick_to_level #(
   parameter int CNT_W   = 8,
   parameter int MIN_LOW = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_in,
   input  logic [CNT_W-1:0] len,
   input  logic             retrigger_en,
   output logic             level_out,
   output logic             busy,
   output logic             done_tick,
   output logic             dropped_tick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] GAP_LOAD = 8'(MIN_LOW);
   localparam bit         HAS_GAP  = (MIN_LOW > 0);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       gap_cnt;

   logic len_ok;
   logic reload;
   logic last_high;
   logic last_gap;

   // Decode the per-edge conditions once, so the FSM below reads in terms of
   // intent. A zero-length request can never start or extend a pulse. The
   // HIGH phase ends on the edge where the counter holds 1, and the GAP phase
   // ends on the edge where the gap counter holds 1.
   always_comb begin
      len_ok    = (len != '0);
      reload    = tick_in && retrigger_en && len_ok;
      last_high = (cnt == CNT_W'(1));
      last_gap  = (gap_cnt == 8'd1);
   end

   // Single registered FSM. Every output is a flop updated together with the
   // state, so level_out and busy always match state_reg exactly, and the two
   // event pulses appear in the cycle after the edge that caused them.
   // In HIGH, a reload is checked before expiry. This means a tick on the
   // expiry edge extends the pulse instead of letting it fall.
   // Done and dropped are evaluated independently, so both may fire together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt          <= '0;
         gap_cnt      <= '0;
         level_out    <= 1'b0;
         busy         <= 1'b0;
         done_tick    <= 1'b0;
         dropped_tick <= 1'b0;
      end else begin
         done_tick    <= 1'b0;
         dropped_tick <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (tick_in) begin
                  if (len_ok) begin
                     cnt       <= len;
                     state_reg <= HIGH;
                     level_out <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     dropped_tick <= 1'b1;
                  end
               end
            end

            HIGH: begin
               if (tick_in && !reload) begin
                  dropped_tick <= 1'b1;
               end
               if (reload) begin
                  cnt <= len;
               end else if (last_high) begin
                  cnt       <= '0;
                  done_tick <= 1'b1;
                  level_out <= 1'b0;
                  if (HAS_GAP) begin
                     state_reg <= GAP;
                     gap_cnt   <= GAP_LOAD;
                  end else begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            GAP: begin
               if (tick_in) begin
                  dropped_tick <= 1'b1;
               end
               if (last_gap) begin
                  state_reg <= IDLE;
                  gap_cnt   <= '0;
                  busy      <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
               cnt       <= '0;
               gap_cnt   <= '0;
               level_out <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tick_to_level.sv
// -----------------------------------------------------------------------------
// tb_tick_to_level
//
// Purpose:
//    Directed bench for tick_to_level with the default parameters
//    (CNT_W = 8, MIN_LOW = 2).
//    Each scenario drives one tick/len/retrigger vector per clock. After each
//    edge it compares the packed outputs {level_out, busy, done_tick,
//    dropped_tick} against hand-derived per-cycle patterns.
//    In every pattern, bit i is the value in the cycle after edge Ei.
// -----------------------------------------------------------------------------
module tb_tick_to_level;

   localparam int CNT_W   = 8;
   localparam int MIN_LOW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             tick_in;
   logic [CNT_W-1:0] len;
   logic             retrigger_en;
   logic             level_out;
   logic             busy;
   logic             done_tick;
   logic             dropped_tick;

   int testsRun    = 0;
   int testsFailed = 0;

   tick_to_level #(
      .CNT_W  (CNT_W),
      .MIN_LOW(MIN_LOW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick_in     (tick_in),
      .len         (len),
      .retrigger_en(retrigger_en),
      .level_out   (level_out),
      .busy        (busy),
      .done_tick   (done_tick),
      .dropped_tick(dropped_tick)
   );

   // 10-unit free-running clock
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs
   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b, expected %b ({level,busy,done,dropped})",
                  tag, observed, expected);
      end
   endtask

   // Drive one vector, let the next rising edge sample it, then settle #1
   task automatic applyStimulus(input logic t, input logic [CNT_W-1:0] l,
                                input logic r, input logic rst);
      tick_in      = t;
      len          = l;
      retrigger_en = r;
      reset        = rst;
      @(posedge clk);
      #1;
   endtask

   // Reset edge with an active tick present, which must be ignored
   task automatic doReset(input string tag);
      applyStimulus(1'b1, 8'd5, 1'b1, 1'b1);
      checkOutput(tag, {level_out, busy, done_tick, dropped_tick}, 4'b0000);
   endtask

   // 16-cycle directed run. len0 is presented at E0, lenLater afterwards.
   task automatic runScenario(input string name, input logic [15:0] ticks,
                              input logic [CNT_W-1:0] len0,
                              input logic [CNT_W-1:0] lenLater,
                              input logic r,
                              input logic [15:0] expLevel,
                              input logic [15:0] expBusy,
                              input logic [15:0] expDone,
                              input logic [15:0] expDrop);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(ticks[i], (i == 0) ? len0 : lenLater, r, 1'b0);
         checkOutput($sformatf("%s[c%0d]", name, i),
                     {level_out, busy, done_tick, dropped_tick},
                     {expLevel[i], expBusy[i], expDone[i], expDrop[i]});
      end
   endtask

   initial begin
      tick_in      = 1'b0;
      len          = '0;
      retrigger_en = 1'b0;
      reset        = 1'b1;

      doReset("reset_initial");

      // len=3: high 3, done after the fall, busy 3 HIGH + 2 GAP
      runScenario("basic", 16'h0001, 8'd3, 8'd3, 1'b0,
                  16'h0007, 16'h001F, 16'h0008, 16'h0000);
      doReset("reset_after_basic");

      // len=4, ticks at E0 and E2 with retrigger: high 6, one done
      runScenario("retrigger", 16'h0005, 8'd4, 8'd4, 1'b1,
                  16'h003F, 16'h00FF, 16'h0040, 16'h0000);
      doReset("reset_after_retrig");

      // Same stimulus without retrigger: high 4, E2 tick dropped
      runScenario("no_retrigger", 16'h0005, 8'd4, 8'd4, 1'b0,
                  16'h000F, 16'h003F, 16'h0010, 16'h0004);
      doReset("reset_after_noretrig");

      // Zero length from IDLE: nothing starts, tick flagged as dropped
      runScenario("zero_len", 16'h0001, 8'd0, 8'd0, 1'b0,
                  16'h0000, 16'h0000, 16'h0000, 16'h0001);
      doReset("reset_after_zero");

      // Tick held high, len=2: high 2 / low 3 period, drops on HIGH and GAP
      runScenario("gap_enforce", 16'hFFFF, 8'd2, 8'd2, 1'b0,
                  16'h8C63, 16'hBDEF, 16'h1084, 16'h7BDE);
      doReset("reset_after_gap");

      // Tick on the expiry edge (cnt==1) retriggers instead of falling
      runScenario("retrig_on_expiry", 16'h0005, 8'd2, 8'd2, 1'b1,
                  16'h000F, 16'h003F, 16'h0010, 16'h0000);
      doReset("reset_after_expiry");

      // Retrigger with len=0 during HIGH is dropped and counting continues
      runScenario("retrig_len0", 16'h0003, 8'd3, 8'd0, 1'b1,
                  16'h0007, 16'h001F, 16'h0008, 16'h0002);
      doReset("reset_after_len0");

      // Long pulse aborted by reset at E50: no done_tick, then a clean restart
      applyStimulus(1'b1, 8'd200, 1'b0, 1'b0);
      checkOutput("long_start", {level_out, busy, done_tick, dropped_tick}, 4'b1100);
      for (int i = 1; i < 50; i++) begin
         applyStimulus(1'b0, 8'd200, 1'b0, 1'b0);
         checkOutput($sformatf("long_hold[e%0d]", i),
                     {level_out, busy, done_tick, dropped_tick}, 4'b1100);
      end
      applyStimulus(1'b0, 8'd200, 1'b0, 1'b1);
      checkOutput("reset_mid_pulse", {level_out, busy, done_tick, dropped_tick}, 4'b0000);
      runScenario("after_reset_len1", 16'h0001, 8'd1, 8'd1, 1'b0,
                  16'h0001, 16'h0007, 16'h0002, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
